// File: rtl/coo_enc_hls_deadlock_detector_if.sv
// ---------------------------------------------------------------------------
// coo_enc_hls_deadlock_detector_if : monitor inputs and deadlock report bus
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface coo_enc_hls_deadlock_detector_if #(
  parameter int NUM_MON = 4,
  parameter int CNT_W   = 16
);
  logic [NUM_MON-1:0] mon_block;
  logic               all_idle;
  logic               clear;
  logic               deadlock;
  logic               report_valid;
  logic               report_ready;
  logic [NUM_MON-1:0] report_mask;
  logic [CNT_W-1:0]   report_time;

  // Detector side drives the report.
  modport master (
    input  mon_block, all_idle, clear, report_ready,
    output deadlock, report_valid, report_mask, report_time
  );

  // Monitor/consumer side.
  modport slave (
    output mon_block, all_idle, clear, report_ready,
    input  deadlock, report_valid, report_mask, report_time
  );
endinterface

`default_nettype wire

// File: rtl/coo_enc_hls_deadlock_detector.sv
// ---------------------------------------------------------------------------
// coo_enc_hls_deadlock_detector : sticky deadlock flag after THRESH blocked cycles
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module coo_enc_hls_deadlock_detector #(
  parameter int NUM_MON = 4,
  parameter int THRESH  = 16,
  parameter int CNT_W   = 16
) (
  input  wire                                   ap_clk,
  input  wire                                   ap_rst_n,
  coo_enc_hls_deadlock_detector_if.master       bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_REPORT = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] c_run_last = CNT_W'(THRESH - 1);
  localparam logic [CNT_W-1:0] c_ts_max   = {CNT_W{1'b1}};

  state_t             r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_run, w_run_nxt;
  logic [NUM_MON-1:0] r_acc, w_acc_nxt;
  logic [CNT_W-1:0]   r_ts;
  logic               r_deadlock, w_deadlock_nxt;
  logic               r_valid, w_valid_nxt;
  logic [NUM_MON-1:0] r_mask, w_mask_nxt;
  logic [CNT_W-1:0]   r_time, w_time_nxt;
  logic               w_any_blk;

  assign w_any_blk = (|bus.mon_block) & ~bus.all_idle;

  always_comb begin
    w_state_nxt    = r_state;
    w_run_nxt      = r_run;
    w_acc_nxt      = r_acc;
    w_deadlock_nxt = r_deadlock;
    w_valid_nxt    = r_valid;
    w_mask_nxt     = r_mask;
    w_time_nxt     = r_time;
    case (r_state)
      S_IDLE: begin
        if (w_any_blk) begin
          w_run_nxt   = CNT_W'(1);
          w_acc_nxt   = bus.mon_block;
          w_state_nxt = S_RUN;
        end else begin
          w_run_nxt = '0;
          w_acc_nxt = '0;
        end
      end
      S_RUN: begin
        if (!w_any_blk) begin
          w_run_nxt   = '0;
          w_acc_nxt   = '0;
          w_state_nxt = S_IDLE;
        end else if (r_run == c_run_last) begin
          // THRESH-th consecutive blocked sample: freeze the report.
          w_deadlock_nxt = 1'b1;
          w_valid_nxt    = 1'b1;
          w_mask_nxt     = r_acc | bus.mon_block;
          w_time_nxt     = r_ts;
          w_run_nxt      = '0;
          w_acc_nxt      = '0;
          w_state_nxt    = S_REPORT;
        end else begin
          w_run_nxt = r_run + CNT_W'(1);
          w_acc_nxt = r_acc | bus.mon_block;
        end
      end
      S_REPORT: begin
        if (bus.report_ready) begin
          w_valid_nxt = 1'b0;
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        w_state_nxt = S_DONE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n || bus.clear) begin
      r_state    <= S_IDLE;
      r_run      <= '0;
      r_acc      <= '0;
      r_ts       <= '0;
      r_deadlock <= 1'b0;
      r_valid    <= 1'b0;
      r_mask     <= '0;
      r_time     <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_run      <= w_run_nxt;
      r_acc      <= w_acc_nxt;
      r_ts       <= (r_ts == c_ts_max) ? r_ts : r_ts + CNT_W'(1);
      r_deadlock <= w_deadlock_nxt;
      r_valid    <= w_valid_nxt;
      r_mask     <= w_mask_nxt;
      r_time     <= w_time_nxt;
    end
  end

  assign bus.deadlock     = r_deadlock;
  assign bus.report_valid = r_valid;
  assign bus.report_mask  = r_mask;
  assign bus.report_time  = r_time;

endmodule

`default_nettype wire

// File: tb/tb_coo_enc_hls_deadlock_detector.sv
// ---------------------------------------------------------------------------
// tb_coo_enc_hls_deadlock_detector : directed self-checking bench
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_coo_enc_hls_deadlock_detector;

  localparam int NUM_MON = 4;
  localparam int THRESH  = 8;
  localparam int CNT_W   = 16;

  logic ap_clk;
  logic ap_rst_n;
  int   n_checks;
  int   n_errors;

  coo_enc_hls_deadlock_detector_if #(.NUM_MON(NUM_MON), .CNT_W(CNT_W)) bus ();

  coo_enc_hls_deadlock_detector #(
    .NUM_MON (NUM_MON),
    .THRESH  (THRESH),
    .CNT_W   (CNT_W)
  ) dut (
    .ap_clk   (ap_clk),
    .ap_rst_n (ap_rst_n),
    .bus      (bus)
  );

  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Advance one edge and sample 1 ns later.
  task automatic step();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic check_cleared(input string tag);
    check({tag, ".deadlock"}, 32'(bus.deadlock), 32'd0);
    check({tag, ".valid"},    32'(bus.report_valid), 32'd0);
    check({tag, ".mask"},     32'(bus.report_mask), 32'd0);
    check({tag, ".time"},     32'(bus.report_time), 32'd0);
  endtask

  task automatic pulse_clear();
    bus.clear = 1'b1;
    step();
    bus.clear = 1'b0;
  endtask

  initial begin
    logic [NUM_MON-1:0] held_mask;
    logic [CNT_W-1:0]   held_time;
    n_checks         = 0;
    n_errors         = 0;
    ap_rst_n         = 1'b0;
    bus.mon_block    = 4'b1111;
    bus.all_idle     = 1'b0;
    bus.clear        = 1'b0;
    bus.report_ready = 1'b0;

    // Reset with blocking present: nothing may be recorded.
    step();
    step();
    check_cleared("reset");

    // Single monitor blocked 8 cycles; timestamp is 7 on the 8th edge.
    ap_rst_n      = 1'b1;
    bus.mon_block = 4'b0100;
    for (int i = 1; i <= THRESH; i++) begin
      step();
      if (i == THRESH - 1) check("t1.before_thresh", 32'(bus.deadlock), 32'd0);
    end
    check("t1.deadlock", 32'(bus.deadlock), 32'd1);
    check("t1.valid",    32'(bus.report_valid), 32'd1);
    check("t1.mask",     32'(bus.report_mask), 32'h4);
    check("t1.time",     32'(bus.report_time), 32'd7);

    // Consumer stalls 5 cycles; inputs change but the report must hold.
    held_mask     = bus.report_mask;
    held_time     = bus.report_time;
    bus.mon_block = 4'b0000;
    for (int i = 0; i < 5; i++) begin
      step();
      check("hs.valid_hold", 32'(bus.report_valid), 32'd1);
      check("hs.mask_hold",  32'(bus.report_mask), 32'h4);
      check("hs.time_hold",  32'(bus.report_time), 32'd7);
      bus.mon_block = (i % 2 == 0) ? 4'b1010 : 4'b0000;
    end
    bus.report_ready = 1'b1;
    step();
    bus.report_ready = 1'b0;
    check("hs.valid_drop",  32'(bus.report_valid), 32'd0);
    check("hs.deadlock",    32'(bus.deadlock), 32'd1);
    check("hs.mask_kept",   32'(bus.report_mask), 32'(held_mask));
    check("hs.time_kept",   32'(bus.report_time), 32'(held_time));

    // Done state: new blocking must not re-detect or re-offer.
    bus.mon_block = 4'b1111;
    for (int i = 0; i < THRESH + 2; i++) step();
    check("done.deadlock", 32'(bus.deadlock), 32'd1);
    check("done.valid",    32'(bus.report_valid), 32'd0);
    check("done.mask",     32'(bus.report_mask), 32'h4);

    pulse_clear();
    check_cleared("clr1");

    // 7 blocked, 1 free, 7 blocked: never reaches threshold.
    for (int i = 0; i < 15; i++) begin
      bus.mon_block = (i == 7) ? 4'b0000 : 4'b0011;
      step();
      check("gap.deadlock", 32'(bus.deadlock), 32'd0);
    end
    bus.mon_block = 4'b0000;
    step();

    // Alternating monitors accumulate into the mask.
    pulse_clear();
    for (int i = 0; i < THRESH; i++) begin
      bus.mon_block = (i % 2 == 0) ? 4'b0001 : 4'b1000;
      step();
    end
    check("alt.deadlock", 32'(bus.deadlock), 32'd1);
    check("alt.valid",    32'(bus.report_valid), 32'd1);
    check("alt.mask",     32'(bus.report_mask), 32'h9);
    check("alt.time",     32'(bus.report_time), 32'd7);

    // Clear mid-handshake drops everything, then a fresh run re-detects.
    pulse_clear();
    check_cleared("clr_rep");
    bus.mon_block = 4'b0010;
    step();
    step();
    bus.mon_block = 4'b0000;
    step();
    bus.mon_block = 4'b0010;
    for (int i = 0; i < THRESH; i++) step();
    check("redet.deadlock", 32'(bus.deadlock), 32'd1);
    check("redet.mask",     32'(bus.report_mask), 32'h2);
    // Clear at ts=0, then edges ts 0..10 sampled; detecting edge sees ts=10.
    check("redet.time",     32'(bus.report_time), 32'd10);

    // all_idle on the 4th cycle breaks the run.
    pulse_clear();
    bus.mon_block = 4'b0010;
    for (int i = 1; i <= THRESH; i++) begin
      bus.all_idle = (i == 4);
      step();
    end
    bus.all_idle = 1'b0;
    check("idle.deadlock", 32'(bus.deadlock), 32'd0);
    check("idle.valid",    32'(bus.report_valid), 32'd0);
    bus.mon_block = 4'b0000;
    step();

    // Clear coinciding with the detecting edge wins.
    pulse_clear();
    bus.mon_block = 4'b0100;
    for (int i = 1; i <= THRESH; i++) begin
      bus.clear = (i == THRESH);
      step();
    end
    bus.clear = 1'b0;
    check_cleared("clr_det");
    // Run must restart from zero: 7 more blocked cycles are not enough.
    for (int i = 0; i < THRESH - 1; i++) step();
    check("clr_det.restart", 32'(bus.deadlock), 32'd0);
    step();
    check("clr_det.redetect", 32'(bus.deadlock), 32'd1);
    check("clr_det.time",     32'(bus.report_time), 32'd7);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/coo_enc_hls_deadlock_detector.md
Name: coo_enc_hls_deadlock_detector

Overview:
- Sits directly downstream of the per-instance HLS deadlock monitors of the coo_enc IP.
- Consumes their registered `block` outputs and asserts a sticky deadlock flag once blocking persists for THRESH consecutive cycles.
- On detection, freezes a report (which monitors blocked, detection timestamp) and offers it to the debug/status logic over a valid/ready handshake.

Parameters:
- NUM_MON, 4: number of monitor `block` inputs aggregated.
- THRESH, 16: consecutive blocked cycles required to declare deadlock. Legal range is 2 to 2^CNT_W-1.
- CNT_W, 16: width of the run counter and the timestamp counter.

Ports:
- ap_clk, input, 1: single clock; all logic on rising edge.
- ap_rst_n, input, 1: synchronous reset, active-low.
- mon_block, input, NUM_MON: registered block flags from the per-instance deadlock monitors.
- all_idle, input, 1: high when every monitored instance is idle; masks blocking.
- clear, input, 1: synchronous clear of detection state and counters.
- deadlock, output, 1: sticky deadlock indication.
- report_valid, output, 1: report available.
- report_ready, input, 1: consumer accepts the report.
- report_mask, output, NUM_MON: OR of mon_block over the blocked run that triggered detection.
- report_time, output, CNT_W: timestamp-counter value on the detection cycle.

Behaviour:
- Reset (ap_rst_n=0 at an edge): state=S_IDLE. deadlock=0, report_valid=0, report_mask=0, report_time=0, run counter=0, timestamp=0.
- Reset overrides clear and all other inputs.
- any_blk = (|mon_block) & ~all_idle, sampled each edge.
- Timestamp counter:
  - Increments every cycle and saturates at 2^CNT_W-1.
  - Zeroed by reset or clear.
- S_IDLE:
  - If any_blk: run=1, acc_mask=mon_block, go to S_RUN.
  - Otherwise stay; run=0, acc_mask=0.
- S_RUN:
  - If !any_blk: run=0, acc_mask=0, go to S_IDLE. A single unblocked cycle breaks the run.
  - Otherwise: acc_mask |= mon_block, run=run+1.
  - If any_blk and run==THRESH-1 on this edge (i.e. this is the THRESH-th consecutive blocked sample):
    - deadlock<=1, report_valid<=1.
    - report_mask<=acc_mask|mon_block.
    - report_time<=timestamp.
    - Go to S_REPORT.
  - Latency: deadlock is visible in the cycle after the THRESH-th consecutive blocked sample.
- S_REPORT:
  - report_valid=1; report_mask and report_time held stable.
  - On report_valid & report_ready at an edge: report_valid<=0, go to S_DONE.
  - mon_block and all_idle are ignored.
- S_DONE:
  - deadlock stays 1 and report data is held; report_valid=0.
  - Stays until clear or reset. No re-detection.
- deadlock is sticky from detection until clear or reset, independent of any later unblocking.
- clear=1 at an edge (ap_rst_n=1):
  - Same state as reset: S_IDLE, all outputs 0, counters 0.
  - Applies in any state, including mid-handshake. report_valid may drop without a handshake in this case only.
- clear and the detecting edge coincide: clear wins, no detection is recorded.
- all_idle=1 forces any_blk=0, so it breaks a run exactly like unblocking.
- run never exceeds THRESH-1 before transition, so no wrap is possible.

Test Plan:
- THRESH=8, NUM_MON=4. After reset, mon_block=4'b0100 for 8 consecutive cycles:
  - deadlock=1 and report_valid=1 on the cycle after the 8th sample.
  - report_mask=4'b0100.
  - report_time = timestamp on the detecting edge.
- mon_block nonzero for 7 cycles, then 0 for 1 cycle, then nonzero for 7 cycles -> deadlock stays 0 throughout.
- Run toggling mon_block between 4'b0001 and 4'b1000 for 8 cycles -> deadlock=1, report_mask=4'b1001.
- After detection, hold report_ready=0 for 5 cycles, then 1 for one cycle:
  - report_valid and data are stable for those 5 cycles, then report_valid=0.
  - deadlock stays 1.
- Either of these breaks the run and yields no detection:
  - mon_block=4'b0010 for 8 cycles with all_idle=1 on cycle 4.
  - clear pulsed on cycle 8 (same edge as detection).
- In S_REPORT, assert clear -> next cycle deadlock=0, report_valid=0, report_mask=0, report_time=0. A fresh 8-cycle run re-detects.
